// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core (C) and an
// external master (E), one transaction at a time over a req/ack handshake.
// Ports: clk, reset (async active-low); c_* core requester; e_* external
// requester; mem_* memory side; err pulses on a memory timeout abort.
// Build option: define DMEM_ARB_FIXED_PRIO_EN so the core always wins ties
// (round-robin between C and E otherwise).
module dmem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    input  logic [3:0]    c_be,
    output logic [DW-1:0] c_rdata,
    output logic          c_done,
    output logic          c_stall,
    input  logic          e_req,
    input  logic          e_we,
    input  logic [AW-1:0] e_addr,
    input  logic [DW-1:0] e_wdata,
    input  logic [3:0]    e_be,
    output logic [DW-1:0] e_rdata,
    output logic          e_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_C,
        BUSY_E,
        DONE
    } state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       expired;
    logic       owner_c;
    logic       grant_c;
    logic       grant_e;

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // 1 when E owned the port most recently; reset value lets C win first
    logic       last_e;
`endif

    assign cnt_nxt = cnt + 8'd1;
    // cnt counts completed BUSY cycles, so this is the TIMEOUT-th one
    assign expired = (cnt_nxt == TO_CNT);
    assign owner_c = (state == BUSY_C);
    assign c_stall = c_req & ~c_done;

    always_comb begin
        grant_c = 1'b0;
        grant_e = 1'b0;
        if (c_req && e_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            grant_c = 1'b1;
`else
            grant_c = last_e;
            grant_e = ~last_e;
`endif
        end else begin
            grant_c = c_req;
            grant_e = e_req;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_e    <= 1'b1;
`endif
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'd0;
            c_rdata   <= '0;
            e_rdata   <= '0;
            c_done    <= 1'b0;
            e_done    <= 1'b0;
            err       <= 1'b0;
        end else begin
            c_done <= 1'b0;
            e_done <= 1'b0;
            err    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_c) begin
                        mem_req   <= 1'b1;
                        mem_we    <= c_we;
                        mem_addr  <= c_addr;
                        mem_wdata <= c_wdata;
                        mem_be    <= c_be;
                        cnt       <= 8'd0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        last_e    <= 1'b0;
`endif
                        state     <= BUSY_C;
                    end else if (grant_e) begin
                        mem_req   <= 1'b1;
                        mem_we    <= e_we;
                        mem_addr  <= e_addr;
                        mem_wdata <= e_wdata;
                        mem_be    <= e_be;
                        cnt       <= 8'd0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        last_e    <= 1'b1;
`endif
                        state     <= BUSY_E;
                    end
                end
                BUSY_C, BUSY_E: begin
                    cnt <= cnt_nxt;
                    // an ack on the expiry cycle still counts as success
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                        if (owner_c) begin
                            c_done <= 1'b1;
                            if (!mem_we) c_rdata <= mem_rdata;
                        end else begin
                            e_done <= 1'b1;
                            if (!mem_we) e_rdata <= mem_rdata;
                        end
                    end else if (expired) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        state   <= DONE;
                        if (owner_c) begin
                            c_done  <= 1'b1;
                            c_rdata <= '0;
                        end else begin
                            e_done  <= 1'b1;
                            e_rdata <= '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a
// transaction-level arbitration/memory model and random traffic.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        logic [31:0] rdata;
    } xact_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          c_req = 1'b0;
    logic          c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic [3:0]    c_be = '0;
    logic [DW-1:0] c_rdata;
    logic          c_done;
    logic          c_stall;
    logic          e_req = 1'b0;
    logic          e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic [3:0]    e_be = '0;
    logic [DW-1:0] e_rdata;
    logic          e_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          err;

    dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_be(c_be), .c_rdata(c_rdata),
        .c_done(c_done), .c_stall(c_stall),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr),
        .e_wdata(e_wdata), .e_be(e_be), .e_rdata(e_rdata),
        .e_done(e_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    xact_t mem_q[$];
    xact_t c_q[$];
    xact_t e_q[$];
    bit    last_e = 1'b1;
    logic [31:0] c_model = '0;
    logic [31:0] e_model = '0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic xact_t rnd_x();
        xact_t x;
        x.we    = 1'($urandom_range(0, 1));
        x.addr  = $urandom;
        x.wdata = $urandom;
        x.be    = 4'($urandom_range(0, 15));
        x.lat   = $urandom_range(1, 6);
        x.rdata = $urandom;
        return x;
    endfunction

    // memory responder: checks each granted access against the model order
    initial begin
        xact_t cur;
        int    cyc;
        bit    active;
        int    dur;
        active = 1'b0;
        cyc    = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                active  = 1'b0;
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (!active) begin
                    active = 1'b1;
                    cyc    = 1;
                    if (mem_q.size() == 0) begin
                        chk("mem_unexpected_req", 32'(mem_req), 32'd0);
                        cur.lat = 1000;
                    end else begin
                        cur = mem_q.pop_front();
                    end
                end else begin
                    cyc++;
                end
                chk("mem_we", 32'(mem_we), 32'(cur.we));
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_wdata", mem_wdata, cur.wdata);
                chk("mem_be", 32'(mem_be), 32'(cur.be));
                mem_ack   = (cyc == cur.lat);
                mem_rdata = mem_ack ? cur.rdata : $urandom;
            end else begin
                if (active) begin
                    dur = (cur.lat < TO) ? cur.lat : TO;
                    chk("mem_req_cycles", 32'(cyc), 32'(dur));
                    active = 1'b0;
                end
                // stray acks while no request is pending must be ignored
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // completion monitor
    initial begin
        xact_t t;
        bit    e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                c_model = '0;
                e_model = '0;
            end else begin
                if (c_done) begin
                    if (c_q.size() == 0) begin
                        chk("c_done_unexpected", 32'(c_done), 32'd0);
                    end else begin
                        t = c_q.pop_front();
                        e = (t.lat > TO);
                        chk("c_err", 32'(err), 32'(e));
                        if (e) c_model = '0;
                        else if (!t.we) c_model = t.rdata;
                    end
                end
                if (e_done) begin
                    if (e_q.size() == 0) begin
                        chk("e_done_unexpected", 32'(e_done), 32'd0);
                    end else begin
                        t = e_q.pop_front();
                        e = (t.lat > TO);
                        chk("e_err", 32'(err), 32'(e));
                        if (e) e_model = '0;
                        else if (!t.we) e_model = t.rdata;
                    end
                end
                if (!c_done && !e_done) chk("err_no_done", 32'(err), 32'd0);
                chk("c_rdata", c_rdata, c_model);
                chk("e_rdata", e_rdata, e_model);
            end
        end
    end

    task automatic run_c();
        int n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (c_done) begin
                chk("c_stall_at_done", 32'(c_stall), 32'd0);
                c_req = 1'b0;
                break;
            end
            chk("c_stall_wait", 32'(c_stall), 32'd1);
            if (n > 40) begin
                chk("c_done_timeout", 32'(c_done), 32'd1);
                c_req = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_e();
        int n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (e_done) begin
                e_req = 1'b0;
                break;
            end
            if (n > 40) begin
                chk("e_done_timeout", 32'(e_done), 32'd1);
                e_req = 1'b0;
                break;
            end
        end
    endtask

    // called at a negedge with the arbiter idle
    task automatic do_round(bit doc, bit doe, xact_t tc, xact_t te);
        bit c_first;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        c_first = 1'b1;
`else
        c_first = last_e;
`endif
        if (doc && doe) begin
            if (c_first) begin
                mem_q.push_back(tc);
                mem_q.push_back(te);
                last_e = 1'b1;
            end else begin
                mem_q.push_back(te);
                mem_q.push_back(tc);
                last_e = 1'b0;
            end
        end else if (doc) begin
            mem_q.push_back(tc);
            last_e = 1'b0;
        end else if (doe) begin
            mem_q.push_back(te);
            last_e = 1'b1;
        end
        if (doc) begin
            c_q.push_back(tc);
            c_we = tc.we; c_addr = tc.addr;
            c_wdata = tc.wdata; c_be = tc.be;
            c_req = 1'b1;
        end
        if (doe) begin
            e_q.push_back(te);
            e_we = te.we; e_addr = te.addr;
            e_wdata = te.wdata; e_be = te.be;
            e_req = 1'b1;
        end
        fork
            begin if (doc) run_c(); end
            begin if (doe) run_e(); end
        join
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    initial begin
        xact_t a;
        xact_t b;
        int    n;
        bit    sc;
        bit    se;

        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_c_done", 32'(c_done), 32'd0);
        chk("rst_e_done", 32'(e_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_c_stall", 32'(c_stall), 32'd0);
        chk("rst_c_rdata", c_rdata, 32'd0);
        chk("rst_e_rdata", e_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // simultaneous writes from reset: C first, then alternation
        a = '{1'b1, 32'h10, 32'h11, 4'hF, 1, 32'h0};
        b = '{1'b1, 32'h20, 32'h22, 4'hF, 1, 32'h0};
        do_round(1'b1, 1'b1, a, b);
        a.addr = 32'h14;
        b.addr = 32'h24;
        do_round(1'b1, 1'b1, a, b);

        // core read, ack on the third request cycle
        a = '{1'b0, 32'h100, 32'h0, 4'hF, 3, 32'hCAFEF00D};
        do_round(1'b1, 1'b0, a, b);

        // external write leaves e_rdata alone
        b = '{1'b1, 32'h2000, 32'h12345678, 4'b0011, 3, 32'h0};
        do_round(1'b0, 1'b1, a, b);

        // ack exactly on the expiry cycle, then a real timeout
        a = '{1'b0, 32'h300, 32'h0, 4'hF, TO, 32'h5A5A1234};
        do_round(1'b1, 1'b0, a, b);
        a = '{1'b0, 32'h304, 32'h0, 4'hF, 100, 32'h0};
        do_round(1'b1, 1'b0, a, b);

        for (int i = 0; i < 150; i++) begin
            n  = $urandom_range(1, 3);
            sc = n[0];
            se = n[1];
            do_round(sc, se, rnd_x(), rnd_x());
        end

        // reset in the middle of an external access
        b = '{1'b0, 32'h4000, 32'h0, 4'hF, 100, 32'h0};
        mem_q.push_back(b);
        e_we = b.we; e_addr = b.addr;
        e_wdata = b.wdata; e_be = b.be;
        e_req = 1'b1;
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_grant", 32'(mem_req), 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_mem_req", 32'(mem_req), 32'd0);
        chk("async_e_done", 32'(e_done), 32'd0);
        chk("async_err", 32'(err), 32'd0);
        e_req = 1'b0;
        mem_q.delete();
        e_q.delete();
        last_e = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        a = '{1'b0, 32'h500, 32'h0, 4'hF, 2, 32'h600DBEEF};
        do_round(1'b1, 1'b0, a, b);
        a = '{1'b1, 32'h504, 32'h77, 4'h1, 1, 32'h0};
        b = '{1'b0, 32'h508, 32'h0, 4'hF, 2, 32'hFEEDFACE};
        do_round(1'b1, 1'b1, a, b);

        repeat (4) @(negedge clk);
        chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
        chk("c_q_empty", 32'(c_q.size()), 32'd0);
        chk("e_q_empty", 32'(e_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
